ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. Sends one command byte (LED set 0xED, enable 0xF4, reset 0xFF) from the system-clock domain to a keyboard or mouse over the shared open-drain PS/2 clock and data lines, then checks the device acknowledge bit. It sits beside the PS/2 keyboard receiver on the same two pins. While `busy` is high, the receiver's output must be ignored, because the receiver also sees our own frame.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_sync.sv | 39 +++
 rtl/ps2_host_tx.sv | 183 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 types, command bytes and frame helpers for the host-side
// transmitter and the keyboard receiver that share the same two pins.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_REQ,
      ST_SEND,
      ST_ACK,
      ST_WAIT_IDLE
   } ps2_state_e;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

   localparam int PS2_FRAME_BITS = 11;

   // Host-driven bits are counted without the start bit, so the stop bit is
   // index 9 (start, 8 data, parity, stop, then the device's ACK slot).
   localparam logic [3:0] PS2_LAST_BIT = 4'(PS2_FRAME_BITS - 2);

   function automatic logic ps2_odd_parity(input logic [7:0] b);
      return ~(^b);
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pads plus falling-edge
// detect on the synchronized values; shared with the receiver.
module ps2_line_sync (
   input  logic clk,
   input  logic areset,
   input  logic ps2_clk_in,
   input  logic ps2_dat_in,
   output logic clk_s,
   output logic dat_s,
   output logic clk_fall,
   output logic dat_fall
);

   // [0] metastability stage, [1] synchronized value, [2] previous sync value
   logic [2:0] clk_pipe_q, clk_pipe_d;
   logic [2:0] dat_pipe_q, dat_pipe_d;

   always_comb begin
      clk_pipe_d = {clk_pipe_q[1:0], ps2_clk_in};
      dat_pipe_d = {dat_pipe_q[1:0], ps2_dat_in};
   end

   // Idle bus is pulled high, so reset to 1 to avoid a false edge after reset.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         clk_pipe_q <= '1;
         dat_pipe_q <= '1;
      end else begin
         clk_pipe_q <= clk_pipe_d;
         dat_pipe_q <= dat_pipe_d;
      end
   end

   assign clk_s    = clk_pipe_q[1];
   assign dat_s    = dat_pipe_q[1];
   assign clk_fall = clk_pipe_q[2] & ~clk_pipe_q[1];
   assign dat_fall = dat_pipe_q[2] & ~dat_pipe_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clock out
// one byte on device clock edges, then check the device acknowledge.
//
// state        | meaning
// ST_IDLE      | lines released, ready for a command byte
// ST_INHIBIT   | holding clock low for the inhibit time
// ST_REQ       | clock released, data low (start bit), watchdog armed
// ST_SEND      | one bit per device clock fall: d0..d7, parity, stop
// ST_ACK       | sample the device ACK on the next clock fall
// ST_WAIT_IDLE | wait for both lines high before reporting done
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       areset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int WDG_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unused_clk_hz = CLK_HZ;

   ps2_state_e state_q, state_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic [3:0]       bitcnt_q, bitcnt_d;
   logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
   logic [WDG_W-1:0] wdog_q, wdog_d;
   logic             clk_oe_q, clk_oe_d;
   logic             dat_oe_q, dat_oe_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             wdog_run, wdog_tc;

   logic clk_s, dat_s, clk_fall, dat_fall;
   logic unused_dat_fall;

   ps2_line_sync u_sync (
      .clk        (clk),
      .areset     (areset),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .clk_s      (clk_s),
      .dat_s      (dat_s),
      .clk_fall   (clk_fall),
      .dat_fall   (dat_fall)
   );

   assign unused_dat_fall = dat_fall;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      par_d     = par_q;
      bitcnt_d  = bitcnt_q;
      inh_cnt_d = inh_cnt_q;
      wdog_d    = wdog_q;
      clk_oe_d  = clk_oe_q;
      dat_oe_d  = dat_oe_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      wdog_run = state_q inside {ST_REQ, ST_SEND, ST_ACK, ST_WAIT_IDLE};
      wdog_tc  = wdog_run && (wdog_q == '0);
      if (wdog_run && !wdog_tc) wdog_d = wdog_q - WDG_W'(1);

      // Expiry takes priority over any clock edge seen in the same cycle.
      if (wdog_tc) begin
         clk_oe_d = 1'b0;
         dat_oe_d = 1'b0;
         err_d    = 1'b1;
         state_d  = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tx_valid) begin
                  shift_d   = tx_data;
                  par_d     = ps2_odd_parity(tx_data);
                  inh_cnt_d = INH_W'(INHIBIT_CYCLES - 1);
                  clk_oe_d  = 1'b1;
                  state_d   = ST_INHIBIT;
               end
            end
            ST_INHIBIT: begin
               if (inh_cnt_q == '0) begin
                  clk_oe_d = 1'b0;
                  dat_oe_d = 1'b1;
                  wdog_d   = WDG_W'(TIMEOUT_CYCLES - 1);
                  state_d  = ST_REQ;
               end else begin
                  inh_cnt_d = inh_cnt_q - INH_W'(1);
               end
            end
            ST_REQ: begin
               bitcnt_d = '0;
               state_d  = ST_SEND;
            end
            ST_SEND: begin
               if (clk_fall) begin
                  if (bitcnt_q < 4'd8) begin
                     dat_oe_d = ~shift_q[0];
                     shift_d  = {1'b0, shift_q[7:1]};
                  end else if (bitcnt_q == 4'd8) begin
                     dat_oe_d = ~par_q;
                  end else begin
                     dat_oe_d = 1'b0;
                  end
                  if (bitcnt_q == PS2_LAST_BIT) state_d  = ST_ACK;
                  else                          bitcnt_d = bitcnt_q + 4'd1;
               end
            end
            ST_ACK: begin
               if (clk_fall) begin
                  if (!dat_s) begin
                     state_d = ST_WAIT_IDLE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_WAIT_IDLE: begin
               if (clk_s && dat_s) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            default: begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               state_d  = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         par_q     <= 1'b0;
         bitcnt_q  <= '0;
         inh_cnt_q <= '0;
         wdog_q    <= '0;
         clk_oe_q  <= 1'b0;
         dat_oe_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         bitcnt_q  <= bitcnt_d;
         inh_cnt_q <= inh_cnt_d;
         wdog_q    <= wdog_d;
         clk_oe_q  <= clk_oe_d;
         dat_oe_q  <= dat_oe_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign tx_ready   = (state_q == ST_IDLE);
   assign busy       = ~tx_ready;
   assign tx_done    = done_q;
   assign tx_err     = err_q;
   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// and a scoreboard checks every done/err pulse against queued expectations.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH  = 5000;
   localparam int TOUT = 10000;
   localparam int H    = 20;

   typedef struct packed {
      logic is_err;
      logic timed;
      int   exp_cyc;
   } res_t;

   logic       clk = 1'b0;
   logic       areset;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready, busy, tx_done, tx_err;
   logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
   logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0;
   logic       dev_busy = 1'b0;
   int         dev_mode = 0;
   int         dev_fall_cnt = 0;
   int         dev_frames = 0;
   int         cyc = 0;
   int         total = 0, bad = 0;

   res_t        res_q[$];
   logic [10:0] frm_q[$];

   ps2_host_tx #(
      .CLK_HZ         (50_000_000),
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TOUT)
   ) dut (
      .clk        (clk),
      .areset     (areset),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .tx_done    (tx_done),
      .tx_err     (tx_err),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe)
   );

   // Open-drain wired-AND of host and device drivers with pull-ups.
   assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every result pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!areset && (tx_done || tx_err)) begin
         res_t e;
         chk("done_err_exclusive", {31'd0, tx_done & tx_err}, 0);
         if (res_q.size() == 0) begin
            chk("unexpected_pulse", {30'd0, tx_done, tx_err}, 0);
         end else begin
            e = res_q.pop_front();
            chk("pulse_kind_err", {31'd0, tx_err}, {31'd0, e.is_err});
            chk("ready_with_pulse", {31'd0, tx_ready}, 1);
            chk("lines_released_at_pulse", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
            if (e.timed) chk("watchdog_latency", cyc, e.exp_cyc);
         end
      end
   end

   // Device model: modes 0 ack, 1 no-ack, 2 silent, 3 clock but do not check.
   initial begin : device
      logic [10:0] bits;
      logic [10:0] ef;
      logic        saw_inh;
      int          mode;
      saw_inh = 1'b0;
      forever begin
         @(negedge clk);
         if (!ps2_clk_in && !dev_clk_low) begin
            saw_inh = 1'b1;
         end else if (saw_inh && ps2_clk_in && !ps2_dat_in) begin
            saw_inh = 1'b0;
            mode = dev_mode;
            if (mode != 2) begin
               dev_busy = 1'b1;
               dev_fall_cnt = 0;
               bits = '0;
               bits[0] = ps2_dat_in;
               repeat (10) @(negedge clk);
               for (int i = 1; i <= 10; i++) begin
                  dev_clk_low = 1'b1;
                  dev_fall_cnt++;
                  repeat (H) @(negedge clk);
                  bits[i] = ps2_dat_in;
                  dev_clk_low = 1'b0;
                  repeat (H) @(negedge clk);
               end
               if (mode != 1) dev_dat_low = 1'b1;
               repeat (H/2) @(negedge clk);
               dev_clk_low = 1'b1;
               repeat (H) @(negedge clk);
               dev_clk_low = 1'b0;
               repeat (H/2) @(negedge clk);
               dev_dat_low = 1'b0;
               if (mode <= 1) begin
                  if (frm_q.size() == 0) begin
                     chk("unexpected_frame", {21'd0, bits}, 0);
                  end else begin
                     ef = frm_q.pop_front();
                     chk("frame_bits", {21'd0, bits}, {21'd0, ef});
                  end
               end
               dev_frames++;
               dev_busy = 1'b0;
            end
         end
      end
   end

   // Issues one byte and returns in the REQ cycle; checks inhibit timing.
   task automatic send_byte(input logic [7:0] b, input logic p, input int mode);
      int k;
      dev_mode = mode;
      if (mode <= 1) frm_q.push_back({1'b1, p, b, 1'b0});
      if (mode == 0) res_q.push_back('{1'b0, 1'b0, 0});
      if (mode == 1) res_q.push_back('{1'b1, 1'b0, 0});
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      chk("ready_before_send", {31'd0, tx_ready}, 1);
      @(negedge clk);
      tx_valid = 1'b0;
      chk("clk_oe_after_handshake", {31'd0, ps2_clk_oe}, 1);
      chk("busy_after_handshake", {31'd0, busy}, 1);
      k = 0;
      while (!ps2_dat_oe && k < INH + 20) begin
         @(negedge clk);
         k++;
      end
      chk("inhibit_length", k, INH);
      chk("clk_released_at_req", {31'd0, ps2_clk_oe}, 0);
      if (mode == 2) res_q.push_back('{1'b1, 1'b1, cyc + TOUT});
   endtask

   task automatic finish_frame(input int budget);
      int k;
      k = 0;
      while (!(tx_ready && !dev_busy) && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("frame_end_in_time", {31'd0, k < budget}, 1);
      repeat (5) @(negedge clk);
   endtask

   initial begin : stim
      int  k;
      int  f0;
      logic got;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      areset   = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_ready", {31'd0, tx_ready}, 1);
      chk("reset_busy", {31'd0, busy}, 0);
      chk("reset_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
      chk("reset_pulses", {30'd0, tx_done, tx_err}, 0);
      areset = 1'b0;
      @(negedge clk);
      chk("idle_ready", {31'd0, tx_ready}, 1);
      chk("idle_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);

      send_byte(PS2_CMD_SET_LED, 1'b1, 0);
      finish_frame(2000);

      send_byte(PS2_CMD_ENABLE, 1'b0, 0);
      finish_frame(2000);

      send_byte(8'h5A, 1'b1, 1);
      finish_frame(2000);

      send_byte(PS2_CMD_SET_LED, 1'b1, 2);
      finish_frame(TOUT + 100);
      chk("oe_after_timeout", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);

      // Reset in the middle of d4 of 0xFF.
      send_byte(PS2_CMD_RESET, 1'b1, 3);
      k = 0;
      while (dev_fall_cnt < 5 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      chk("reached_bit4", {31'd0, k < 2000}, 1);
      repeat (6) @(negedge clk);
      chk("busy_before_reset", {31'd0, busy}, 1);
      #2 areset = 1'b1;
      #1;
      chk("reset_oe_async", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
      chk("reset_ready_async", {31'd0, tx_ready}, 1);
      chk("reset_no_pulse", {30'd0, tx_done, tx_err}, 0);
      repeat (2) @(negedge clk);
      areset = 1'b0;
      finish_frame(2000);

      send_byte(8'h00, 1'b1, 0);
      finish_frame(2000);

      // tx_valid held: second handshake lands in the tx_done cycle.
      dev_mode = 0;
      frm_q.push_back({1'b1, 1'b0, PS2_CMD_ENABLE, 1'b0});
      frm_q.push_back({1'b1, 1'b0, PS2_CMD_ENABLE, 1'b0});
      res_q.push_back('{1'b0, 1'b0, 0});
      res_q.push_back('{1'b0, 1'b0, 0});
      f0 = dev_frames;
      @(negedge clk);
      tx_data  = PS2_CMD_ENABLE;
      tx_valid = 1'b1;
      got = 1'b0;
      k = 0;
      while (!got && k < 8000) begin
         @(negedge clk);
         k++;
         if (tx_done) got = 1'b1;
      end
      chk("hold_first_done", {31'd0, got}, 1);
      chk("hold_handshake_in_done", {31'd0, tx_ready & tx_valid}, 1);
      @(negedge clk);
      chk("hold_second_inhibit", {31'd0, ps2_clk_oe}, 1);
      tx_valid = 1'b0;
      finish_frame(8000);
      repeat (20) @(negedge clk);
      chk("hold_frame_count", dev_frames - f0, 2);
      chk("hold_no_third", {31'd0, busy}, 0);

      repeat (20) @(negedge clk);
      chk("results_left", res_q.size(), 0);
      chk("frames_left", frm_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
